sipo_frame_ctrl: RTL and testbench
==================================

SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, number of data bits per frame; legal range is WIDTH >= 2.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: bit_en  input  1  bit strobe; sdata is sampled only on clk edges where bit_en=1.
REQ-005 Port: sdata  input  1  serial line; idles at 1.
REQ-006 Port: out_data  output  WIDTH  last accepted word, with the first-received bit in the MSB.
REQ-007 Port: out_valid  output  1  out_data holds an unconsumed word.
REQ-008 Port: out_ready  input  1  consumer accepts the word when out_valid=1 and out_ready=1 on a clk edge.
REQ-009 Port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-010 Port: frame_err  output  1  one-cycle pulse signalling a bad stop bit.
REQ-011 Port: overrun  output  1  one-cycle pulse signalling a word dropped because the output buffer was full.

Function
REQ-012 The block SHALL sequence an internal WIDTH-bit shift-left register, shift_q <= {shift_q[WIDTH-2:0], sdata}, through a frame of: start bit (0), WIDTH data bits (MSB first), stop bit (1).
REQ-013 The FSM SHALL have three states: IDLE, DATA, STOP; all transitions occur only on edges with bit_en=1.
REQ-014 IDLE: bit_en=1 and sdata=0 -> DATA with bit counter=0; bit_en=1 and sdata=1 -> stay in IDLE.
REQ-015 DATA: on each bit_en=1, shift sdata into shift_q and increment the counter; on the strobe where counter==WIDTH-1, go to STOP.
REQ-016 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never wrap within a frame.
REQ-017 STOP with sdata=1: deliver shift_q to the output buffer per REQ-019/020, then go to IDLE.
REQ-018 STOP with sdata=0: assert frame_err for exactly one cycle, discard the word, leave out_data/out_valid unchanged, go to IDLE.
REQ-019 Delivery when out_valid=0, or out_valid=1 and out_ready=1 on the same edge: out_data <= shift_q and out_valid <= 1; no overrun.
REQ-020 Delivery when out_valid=1 and out_ready=0: drop the new word, keep out_data, and pulse overrun for exactly one cycle.
REQ-021 Handshake on a non-delivery edge with out_valid=1 and out_ready=1: out_valid <= 0 on that edge.
REQ-022 out_data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 Latency: out_valid SHALL be high in the cycle after the edge that samples a good stop bit.
REQ-024 With bit_en=0, the FSM, counter, and shift_q SHALL hold; the output handshake continues to operate.
REQ-025 frame_err and overrun SHALL never be high in the same cycle.
REQ-026 busy SHALL be combinational on the state register: busy = (state != IDLE).

Reset
REQ-027 reset=1 SHALL force, asynchronously: state=IDLE, counter=0, shift_q=0, out_data=0, out_valid=0, frame_err=0, overrun=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL abandon the frame without any delivery or error pulse.
REQ-029 After reset deassertion, the next start bit SHALL be recognised normally.

Verification (WIDTH=4)
REQ-030 Bits 0,1,0,1,1,1 on consecutive strobes, out_ready=0 -> out_data=4'b1011 and out_valid=1 from the cycle after the stop edge; frame_err=0, overrun=0.
REQ-031 Same frame as REQ-030 with bit_en high only every 3rd cycle -> identical out_data=4'b1011; busy high from the start edge through the stop edge.
REQ-032 Frame 0,1,1,0,0 followed by stop=0 -> frame_err pulses for 1 cycle; out_valid stays 0.
REQ-033 Frame with data 1011, then frame with data 0110, out_ready=0 throughout -> overrun pulses for 1 cycle at the second stop; out_data stays 4'b1011.
REQ-034 Repeat REQ-033 but with out_ready=1 on the second stop edge -> no overrun; out_data=4'b0110; out_valid stays 1.
REQ-035 reset pulsed after 2 data bits -> all outputs 0 immediately; a subsequent frame with data 1001 -> out_data=4'b1001.

Source files
------------

// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out framer: start bit, WIDTH data bits (MSB first), stop bit.
// A good word lands in a one-deep valid/ready output buffer. A bad stop bit or a full buffer raises a one-cycle pulse.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_en,
  input  logic             sdata,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  // Output handshake: a word transfers on any edge with out_valid=1 and out_ready=1.
  // A delivery on that same edge refills the buffer, so back-to-back words are not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bit_en && !sdata) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_en) begin
          shift_d = {shift_q[WIDTH-2:0], sdata};
          // Counter parks on the last index instead of wrapping; IDLE re-zeroes it.
          if (cnt_q == LAST_BIT) begin
            state_d = S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (bit_en) begin
          state_d = S_IDLE;
          if (!sdata) begin
            frame_err_d = 1'b1;
          end else if (!out_valid_q || out_ready) begin
            out_data_d  = shift_q;
            out_valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign frame_err   = frame_err_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q != S_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed bench for sipo_frame_ctrl (WIDTH=4).
// Inputs change on the falling edge, and outputs are checked on the falling edge after each rising edge.
module tb_sipo_frame_ctrl;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         bit_en = 1'b0;
  logic         sdata = 1'b1;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         busy;
  logic         frame_err;
  logic         overrun;
  logic [1:0]   dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bit_en      (bit_en),
    .sdata       (sdata),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One strobed bit, followed by 'gap' idle cycles; returns on a falling edge.
  task automatic strobe(input logic b, input int gap);
    bit_en = 1'b1;
    sdata  = b;
    @(negedge clk);
    bit_en = 1'b0;
    sdata  = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic stop, input int gap);
    strobe(1'b0, gap);
    for (int i = W - 1; i >= 0; i--) strobe(d[i], gap);
    strobe(stop, gap);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Good frame on consecutive strobes
    strobe(1'b0, 0);
    check("t1_busy_start", 32'(busy), 32'h1);
    check("t1_state_data", 32'(dbg_state), 32'h1);
    strobe(1'b1, 0); strobe(1'b0, 0); strobe(1'b1, 0); strobe(1'b1, 0);
    check("t1_state_stop", 32'(dbg_state), 32'h2);
    check("t1_valid_pre", 32'(out_valid), 32'h0);
    strobe(1'b1, 0);
    check("t1_out_data", 32'(out_data), 32'hB);
    check("t1_out_valid", 32'(out_valid), 32'h1);
    check("t1_frame_err", 32'(frame_err), 32'h0);
    check("t1_overrun", 32'(overrun), 32'h0);
    check("t1_busy_end", 32'(busy), 32'h0);
    @(negedge clk);
    check("t1_valid_hold", 32'(out_valid), 32'h1);
    check("t1_data_hold", 32'(out_data), 32'hB);
    consume();
    check("t1_valid_consumed", 32'(out_valid), 32'h0);

    // Same frame, strobe every 3rd cycle
    strobe(1'b0, 2);
    check("t2_busy_gap0", 32'(busy), 32'h1);
    strobe(1'b1, 2); strobe(1'b0, 2);
    check("t2_busy_gap2", 32'(busy), 32'h1);
    strobe(1'b1, 2); strobe(1'b1, 2);
    check("t2_busy_before_stop", 32'(busy), 32'h1);
    check("t2_valid_before_stop", 32'(out_valid), 32'h0);
    strobe(1'b1, 0);
    check("t2_out_data", 32'(out_data), 32'hB);
    check("t2_out_valid", 32'(out_valid), 32'h1);
    check("t2_busy_end", 32'(busy), 32'h0);
    consume();

    // Bad stop bit
    send_frame(4'b1100, 1'b0, 0);
    check("t3_frame_err", 32'(frame_err), 32'h1);
    check("t3_overrun", 32'(overrun), 32'h0);
    check("t3_out_valid", 32'(out_valid), 32'h0);
    @(negedge clk);
    check("t3_frame_err_gone", 32'(frame_err), 32'h0);
    check("t3_out_valid_after", 32'(out_valid), 32'h0);

    // Overrun: second word arrives while the buffer is still full
    send_frame(4'b1011, 1'b1, 0);
    check("t4_first_valid", 32'(out_valid), 32'h1);
    send_frame(4'b0110, 1'b1, 0);
    check("t4_overrun", 32'(overrun), 32'h1);
    check("t4_frame_err", 32'(frame_err), 32'h0);
    check("t4_out_data_kept", 32'(out_data), 32'hB);
    check("t4_out_valid", 32'(out_valid), 32'h1);
    @(negedge clk);
    check("t4_overrun_gone", 32'(overrun), 32'h0);
    consume();

    // Consumer accepts on the second stop edge: new word replaces the old one
    send_frame(4'b1011, 1'b1, 0);
    strobe(1'b0, 0);
    strobe(1'b0, 0); strobe(1'b1, 0); strobe(1'b1, 0); strobe(1'b0, 0);
    out_ready = 1'b1;
    strobe(1'b1, 0);
    out_ready = 1'b0;
    check("t5_overrun", 32'(overrun), 32'h0);
    check("t5_out_data", 32'(out_data), 32'h6);
    check("t5_out_valid", 32'(out_valid), 32'h1);

    // Asynchronous reset mid-frame, with a word still held in the buffer
    strobe(1'b0, 0); strobe(1'b1, 0); strobe(1'b0, 0);
    check("t6_busy_mid", 32'(busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_out_data", 32'(out_data), 32'h0);
    check("t6_rst_out_valid", 32'(out_valid), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_frame_err", 32'(frame_err), 32'h0);
    check("t6_rst_overrun", 32'(overrun), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_frame(4'b1001, 1'b1, 0);
    check("t6_out_data", 32'(out_data), 32'h9);
    check("t6_out_valid", 32'(out_valid), 32'h1);
    check("t6_frame_err", 32'(frame_err), 32'h0);
    check("t6_overrun", 32'(overrun), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
